ddr4_x8_chip_model: RTL and testbench

- Cycle-based behavioural model of a single x8 DDR4 SDRAM device: 8Gb organisation, 4 bank groups x 4 banks, BL8 only.
- Nine instances sit behind a DIMM wrapper to form a 72-bit ECC rank for memory-controller simulation.
- Decodes DDR4 commands at the clock edge, tracks open rows per bank, stores burst data in a reduced backing array and returns read data after a fixed latency.
- Double-rate data is presented as two beats per clock on split in/out buses.

---
 rtl/ddr4_x8_chip_model_if.sv | 37 +++
 rtl/ddr4_x8_chip_model.sv | 187 ++++++++++++++++++
 tb/tb_ddr4_x8_chip_model.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_x8_chip_model_if.sv
// Pin bundle between a memory-controller model and one x8 DDR4 device model.
// A command is valid in any cycle with cke=1 and cs_n=0; there is no backpressure.
interface ddr4_x8_chip_model_if;
  logic        model_enable;
  logic        reset_n;
  logic        cke;
  logic        cs_n;
  logic        act_n;
  logic        ras_n_a16;
  logic        cas_n_a15;
  logic        we_n_a14;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic [13:0] addr;
  logic        odt;
  logic        parity;
  logic        pwr;
  logic [15:0] dq_in;
  logic [1:0]  dm_n_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        dqs_oe;
  logic        cmd_err;
  logic [15:0] dbg_bank_open;

  modport master (
    output model_enable, reset_n, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14,
           bg, ba, addr, odt, parity, pwr, dq_in, dm_n_in,
    input  dq_out, dq_oe, dqs_oe, cmd_err, dbg_bank_open
  );

  modport slave (
    input  model_enable, reset_n, cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14,
           bg, ba, addr, odt, parity, pwr, dq_in, dm_n_in,
    output dq_out, dq_oe, dqs_oe, cmd_err, dbg_bank_open
  );
endinterface

// File: rtl/ddr4_x8_chip_model.sv
// Cycle-based x8 DDR4 device model: command decode, per-bank open rows,
// reduced backing store, fixed-latency BL8 read/write data pipelines.
module ddr4_x8_chip_model #(
  parameter int CL            = 16,
  parameter int CWL           = 12,
  parameter int ROW_BITS_IMPL = 4,
  parameter int COL_BITS      = 10
) (
  input logic                  ck_t,
  input logic                  sys_reset,
  ddr4_x8_chip_model_if.slave  bus
);
  localparam int IDX_W  = 4 + ROW_BITS_IMPL + COL_BITS - 3;
  localparam int NWORDS = 1 << IDX_W;

  logic                     w_rst;
  logic                     w_cmd_v;
  logic [3:0]               w_bank;
  logic [2:0]               w_op;
  logic [15:0]              r_open, w_open_nxt;
  logic [ROW_BITS_IMPL-1:0] r_row [16];
  logic [7:0][13:0]         r_mr;
  logic                     w_err, w_rd_issue, w_wr_issue, w_act_set, w_mr_we;
  logic [IDX_W-1:0]         w_idx;

  logic [CL-1:0]            r_rd_pv;
  logic [IDX_W-1:0]         r_rd_pi [CL];
  logic [CWL-1:0]           r_wr_pv;
  logic [IDX_W-1:0]         r_wr_pi [CWL];

  logic                     r_rd_act, r_wr_act, r_both;
  logic [1:0]               r_rd_nxt, r_wr_nxt;
  logic [63:0]              r_rd_word, r_wr_word;
  logic [IDX_W-1:0]         r_wr_idx;
  logic [15:0]              r_dq_out;
  logic                     r_dq_oe, r_cmd_err;

  logic [NWORDS-1:0]        r_valid;
  logic [63:0]              r_mem [NWORDS];

  logic                     w_rd_start, w_wr_start, w_rd_drive, w_wr_cap, w_commit, w_both;
  logic [IDX_W-1:0]         w_rd_sidx, w_wr_sidx;
  logic [63:0]              w_rd_fetch, w_wr_base, w_wr_merged;
  logic [1:0]               w_wr_pair;
  logic                     w_unused;

  function automatic logic [63:0] merge_pair(input logic [63:0] base, input logic [1:0] p,
                                             input logic [15:0] d, input logic [1:0] m_n);
    logic [63:0] r;
    r = base;
    if (m_n[0]) r[{p, 4'b0000} +: 8] = d[7:0];
    if (m_n[1]) r[{p, 4'b1000} +: 8] = d[15:8];
    return r;
  endfunction

  assign w_rst   = sys_reset | ~bus.reset_n | ~bus.model_enable;
  assign w_cmd_v = bus.cke & ~bus.cs_n;
  assign w_bank  = {bus.bg, bus.ba};
  assign w_op    = {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14};
  assign w_idx   = {bus.bg, bus.ba, r_row[w_bank], bus.addr[COL_BITS-1:3]};

  always_comb begin
    w_err      = 1'b0;
    w_rd_issue = 1'b0;
    w_wr_issue = 1'b0;
    w_act_set  = 1'b0;
    w_mr_we    = 1'b0;
    w_open_nxt = r_open;
    if (w_cmd_v) begin
      if (!bus.act_n) begin
        if (r_open[w_bank]) w_err = 1'b1;
        else begin
          w_open_nxt[w_bank] = 1'b1;
          w_act_set          = 1'b1;
        end
      end else begin
        case (w_op)
          3'b000: w_mr_we = 1'b1;
          3'b001: w_err = |r_open;
          3'b010: begin
            if (bus.addr[10]) w_open_nxt = '0;
            else              w_open_nxt[w_bank] = 1'b0;
          end
          3'b100, 3'b101: begin
            if (!r_open[w_bank]) w_err = 1'b1;
            else begin
              w_wr_issue = (w_op == 3'b100);
              w_rd_issue = (w_op == 3'b101);
              if (bus.addr[10]) w_open_nxt[w_bank] = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Burst engines start when a command reaches the end of its latency pipe;
  // a newer start simply overrides an unfinished burst.
  assign w_rd_start  = r_rd_pv[CL-1];
  assign w_rd_sidx   = r_rd_pi[CL-1];
  assign w_rd_fetch  = r_valid[w_rd_sidx] ? r_mem[w_rd_sidx] : 64'd0;
  assign w_rd_drive  = w_rd_start | r_rd_act;

  assign w_wr_start  = r_wr_pv[CWL-1];
  assign w_wr_sidx   = r_wr_pi[CWL-1];
  assign w_wr_base   = w_wr_start ? (r_valid[w_wr_sidx] ? r_mem[w_wr_sidx] : 64'd0) : r_wr_word;
  assign w_wr_pair   = w_wr_start ? 2'd0 : r_wr_nxt;
  assign w_wr_cap    = w_wr_start | r_wr_act;
  assign w_wr_merged = merge_pair(w_wr_base, w_wr_pair, bus.dq_in, bus.dm_n_in);
  assign w_commit    = r_wr_act & ~w_wr_start & (r_wr_nxt == 2'd3);
  assign w_both      = w_rd_drive & w_wr_cap;

  always_ff @(posedge ck_t) begin
    if (w_rst) begin
      r_open    <= '0;
      r_mr      <= '0;
      r_rd_pv   <= '0;
      r_wr_pv   <= '0;
      r_rd_act  <= 1'b0;
      r_rd_nxt  <= 2'd0;
      r_rd_word <= '0;
      r_wr_act  <= 1'b0;
      r_wr_nxt  <= 2'd0;
      r_wr_word <= '0;
      r_wr_idx  <= '0;
      r_dq_out  <= '0;
      r_dq_oe   <= 1'b0;
      r_cmd_err <= 1'b0;
      r_both    <= 1'b0;
      r_valid   <= '0;
    end else begin
      r_open  <= w_open_nxt;
      if (w_mr_we && ({bus.bg[0], bus.ba} != 3'd7)) r_mr[{bus.bg[0], bus.ba}] <= bus.addr;
      r_rd_pv <= {r_rd_pv[CL-2:0], w_rd_issue};
      r_wr_pv <= {r_wr_pv[CWL-2:0], w_wr_issue};

      if (w_rd_start) begin
        r_rd_word <= w_rd_fetch;
        r_dq_out  <= w_rd_fetch[15:0];
        r_rd_act  <= 1'b1;
        r_rd_nxt  <= 2'd1;
      end else if (r_rd_act) begin
        r_dq_out  <= r_rd_word[{r_rd_nxt, 4'b0000} +: 16];
        r_rd_act  <= (r_rd_nxt != 2'd3);
        r_rd_nxt  <= r_rd_nxt + 2'd1;
      end else begin
        r_dq_out  <= '0;
      end
      r_dq_oe <= w_rd_drive;

      if (w_wr_start) begin
        r_wr_word <= w_wr_merged;
        r_wr_idx  <= w_wr_sidx;
        r_wr_act  <= 1'b1;
        r_wr_nxt  <= 2'd1;
      end else if (r_wr_act) begin
        r_wr_word <= w_wr_merged;
        r_wr_act  <= (r_wr_nxt != 2'd3);
        r_wr_nxt  <= r_wr_nxt + 2'd1;
      end
      if (w_commit) r_valid[r_wr_idx] <= 1'b1;

      r_cmd_err <= w_err | (w_both & ~r_both);
      r_both    <= w_both;
    end
  end

  // Storage, row tags and pipe payloads carry no reset; validity lives in the flags above.
  always_ff @(posedge ck_t) begin
    if (!w_rst && w_commit)  r_mem[r_wr_idx] <= w_wr_merged;
    if (!w_rst && w_act_set) r_row[w_bank]   <= bus.addr[ROW_BITS_IMPL-1:0];
    r_rd_pi[0] <= w_idx;
    r_wr_pi[0] <= w_idx;
    for (int i = 1; i < CL; i++)  r_rd_pi[i] <= r_rd_pi[i-1];
    for (int i = 1; i < CWL; i++) r_wr_pi[i] <= r_wr_pi[i-1];
  end

  assign bus.dq_out        = r_dq_out;
  assign bus.dq_oe         = r_dq_oe;
  assign bus.dqs_oe        = r_dq_oe;
  assign bus.cmd_err       = r_cmd_err;
  assign bus.dbg_bank_open = r_open;

  // Mode registers are held only; latencies come from the parameters.
  assign w_unused = ^{bus.odt, bus.parity, bus.pwr, r_mr};
endmodule

// File: tb/tb_ddr4_x8_chip_model.sv
// Directed bench for ddr4_x8_chip_model: write/read, masking, auto-precharge,
// command errors, seamless reads, bank precharge and mid-burst reset.
module tb_ddr4_x8_chip_model;
  localparam int CL  = 16;
  localparam int CWL = 12;

  logic ck_t = 1'b0;
  logic sys_reset;
  always #5 ck_t = ~ck_t;

  ddr4_x8_chip_model_if bus();

  ddr4_x8_chip_model #(.CL(CL), .CWL(CWL), .ROW_BITS_IMPL(4), .COL_BITS(10)) dut (
    .ck_t      (ck_t),
    .sys_reset (sys_reset),
    .bus       (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  localparam logic [63:0] DATA1  = 64'h8877665544332211;
  localparam logic [63:0] DATA_A = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] DATA2  = 64'h0807060504030201;
  localparam logic [63:0] MERGED = 64'h08070605AA030201;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one command for the next rising edge; returns #1 after that edge.
  task automatic issue(input logic a_n, input logic [2:0] op, input logic [1:0] g,
                       input logic [1:0] b, input logic [13:0] ad);
    @(negedge ck_t);
    bus.cs_n      = 1'b0;
    bus.act_n     = a_n;
    {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = op;
    bus.bg        = g;
    bus.ba        = b;
    bus.addr      = ad;
    @(posedge ck_t);
    #1;
    bus.cs_n      = 1'b1;
    bus.act_n     = 1'b1;
    {bus.ras_n_a16, bus.cas_n_a15, bus.we_n_a14} = 3'b111;
  endtask

  task automatic act(input logic [1:0] g, input logic [1:0] b, input logic [15:0] row,
                     input logic exp_err);
    issue(1'b0, row[15:13], g, b, {1'b0, row[12:0]});
    chk("act_err", bus.cmd_err, exp_err);
  endtask

  task automatic wr_burst(input logic [1:0] g, input logic [1:0] b, input logic [9:0] col,
                          input logic [63:0] data, input logic [7:0] mask);
    issue(1'b1, 3'b100, g, b, {4'b0000, col});
    chk("wr_err", bus.cmd_err, 1'b0);
    for (int k = 1; k <= CWL + 3; k++) begin
      @(negedge ck_t);
      if (k >= CWL) begin
        bus.dq_in   = data[16*(k-CWL) +: 16];
        bus.dm_n_in = mask[2*(k-CWL) +: 2];
      end
      @(posedge ck_t);
    end
    @(negedge ck_t);
    bus.dq_in   = 16'h0;
    bus.dm_n_in = 2'b11;
    repeat (2) @(posedge ck_t);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] g, input logic [1:0] b,
                          input logic [9:0] col, input logic ap, input logic [63:0] exp_word,
                          input logic exp_err);
    logic on;
    issue(1'b1, 3'b101, g, b, {3'b000, ap, col});
    chk({tag, "_err"}, bus.cmd_err, exp_err);
    for (int k = 1; k <= CL + 5; k++) begin
      @(posedge ck_t);
      #1;
      on = !exp_err && (k >= CL) && (k <= CL + 3);
      if (k == 1) chk({tag, "_err_pulse"}, bus.cmd_err, 1'b0);
      chk({tag, "_oe"}, bus.dq_oe, on);
      chk({tag, "_dqs_oe"}, bus.dqs_oe, on);
      chk({tag, "_dq"}, bus.dq_out, on ? exp_word[16*(k-CL) +: 16] : 16'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic on;
    sys_reset        = 1'b1;
    bus.model_enable = 1'b1;
    bus.reset_n      = 1'b1;
    bus.cke          = 1'b1;
    bus.cs_n         = 1'b1;
    bus.act_n        = 1'b1;
    bus.ras_n_a16    = 1'b1;
    bus.cas_n_a15    = 1'b1;
    bus.we_n_a14     = 1'b1;
    bus.bg           = 2'd0;
    bus.ba           = 2'd0;
    bus.addr         = 14'd0;
    bus.odt          = 1'b0;
    bus.parity       = 1'b0;
    bus.pwr          = 1'b1;
    bus.dq_in        = 16'h0;
    bus.dm_n_in      = 2'b11;

    // clock / reset
    repeat (3) @(posedge ck_t);
    #1;
    chk("rst_oe", bus.dq_oe, 1'b0);
    chk("rst_dqs_oe", bus.dqs_oe, 1'b0);
    chk("rst_dq", bus.dq_out, 16'h0);
    chk("rst_err", bus.cmd_err, 1'b0);
    chk("rst_open", bus.dbg_bank_open, 16'h0);
    @(negedge ck_t);
    sys_reset = 1'b0;

    // basic write / read on bank bg=1 ba=2 (index 6)
    act(2'd1, 2'd2, 16'h0005, 1'b0);
    chk("open_after_act", bus.dbg_bank_open, 16'h0040);
    wr_burst(2'd1, 2'd2, 10'h010, DATA1, 8'hFF);
    rd_check("rd1", 2'd1, 2'd2, 10'h010, 1'b0, DATA1, 1'b0);

    // byte mask on beat 3
    wr_burst(2'd1, 2'd2, 10'h020, DATA_A, 8'hFF);
    wr_burst(2'd1, 2'd2, 10'h020, DATA2, 8'b1111_0111);
    rd_check("rd_mask", 2'd1, 2'd2, 10'h020, 1'b0, MERGED, 1'b0);

    // never-written location reads as zero
    rd_check("rd_empty", 2'd1, 2'd2, 10'h030, 1'b0, 64'h0, 1'b0);

    // auto-precharge then read to closed bank
    rd_check("rd_ap", 2'd1, 2'd2, 10'h010, 1'b1, DATA1, 1'b0);
    chk("open_after_ap", bus.dbg_bank_open, 16'h0000);
    rd_check("rd_closed", 2'd1, 2'd2, 10'h010, 1'b0, 64'h0, 1'b1);

    // ACT to an open bank and REF with a bank open are rejected
    act(2'd1, 2'd2, 16'h0005, 1'b0);
    act(2'd1, 2'd2, 16'h0007, 1'b1);
    @(posedge ck_t);
    #1;
    chk("act_err_pulse", bus.cmd_err, 1'b0);
    issue(1'b1, 3'b001, 2'd0, 2'd0, 14'd0);
    chk("ref_open_err", bus.cmd_err, 1'b1);
    chk("open_after_errs", bus.dbg_bank_open, 16'h0040);
    rd_check("rd_row_kept", 2'd1, 2'd2, 10'h010, 1'b0, DATA1, 1'b0);

    // precharge single bank and all banks
    act(2'd0, 2'd0, 16'h0001, 1'b0);
    act(2'd3, 2'd3, 16'h0002, 1'b0);
    chk("open_three", bus.dbg_bank_open, 16'h8041);
    issue(1'b1, 3'b010, 2'd0, 2'd0, 14'd0);
    chk("pre_one", bus.dbg_bank_open, 16'h8040);
    issue(1'b1, 3'b010, 2'd0, 2'd0, 14'h0400);
    chk("pre_all", bus.dbg_bank_open, 16'h0000);
    issue(1'b1, 3'b001, 2'd0, 2'd0, 14'd0);
    chk("ref_idle_ok", bus.cmd_err, 1'b0);
    act(2'd1, 2'd2, 16'h0005, 1'b0);

    // seamless reads four cycles apart
    for (int i = 0; i < 4; i++) exp_q.push_back(DATA1[16*i +: 16]);
    for (int i = 0; i < 4; i++) exp_q.push_back(MERGED[16*i +: 16]);
    issue(1'b1, 3'b101, 2'd1, 2'd2, 14'h0010);
    repeat (3) @(posedge ck_t);
    issue(1'b1, 3'b101, 2'd1, 2'd2, 14'h0020);
    for (int k = 5; k <= CL + 9; k++) begin
      @(posedge ck_t);
      #1;
      on = (k >= CL) && (k <= CL + 7);
      chk("b2b_oe", bus.dq_oe, on);
      if (on && exp_q.size() > 0) chk("b2b_dq", bus.dq_out, exp_q.pop_front());
      else                        chk("b2b_dq_idle", bus.dq_out, 16'h0);
    end
    chk("b2b_q_empty", exp_q.size(), 0);

    // reset in the middle of a read burst
    issue(1'b1, 3'b101, 2'd1, 2'd2, 14'h0010);
    for (int k = 1; k <= CL + 1; k++) begin
      @(posedge ck_t);
      #1;
    end
    chk("mid_oe_before", bus.dq_oe, 1'b1);
    chk("mid_dq_before", bus.dq_out, DATA1[31:16]);
    @(negedge ck_t);
    sys_reset = 1'b1;
    @(posedge ck_t);
    #1;
    chk("mid_oe_after", bus.dq_oe, 1'b0);
    chk("mid_dq_after", bus.dq_out, 16'h0);
    chk("mid_open_after", bus.dbg_bank_open, 16'h0);
    @(negedge ck_t);
    sys_reset = 1'b0;
    rd_check("rd_after_rst", 2'd1, 2'd2, 10'h010, 1'b0, 64'h0, 1'b1);

    // DRAM RESET_n acts like the system reset
    act(2'd1, 2'd2, 16'h0005, 1'b0);
    chk("open_before_rstn", bus.dbg_bank_open, 16'h0040);
    @(negedge ck_t);
    bus.reset_n = 1'b0;
    @(posedge ck_t);
    #1;
    chk("open_after_rstn", bus.dbg_bank_open, 16'h0000);
    @(negedge ck_t);
    bus.reset_n = 1'b1;
    repeat (2) @(posedge ck_t);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
